// File: rtl/ex_ff_stage.sv
// ex_ff_stage: EX->FF pipeline register for the dual-issue SPU.
// Carries per-pipe rt result/address/write-enable/unit-id plus memory address
// and branch info across a valid/ready handshake, with flush and a saturating
// stall counter.
// Optional feature: define EX_FF_SKID_EN to add a one-entry skid buffer so that
// in_ready becomes a registered signal, not a combinational function of out_ready.
module ex_ff_stage #(
  parameter int NUM_PIPES = 2,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 7,
  parameter int UID_W     = 3,
  parameter int PC_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_PIPES*DATA_W-1:0]   ex_rt,
  input  logic [NUM_PIPES*ADDR_W-1:0]   ex_rtaddr,
  input  logic [NUM_PIPES-1:0]          ex_wreg,
  input  logic [NUM_PIPES*UID_W-1:0]    ex_uid,
  input  logic [PC_W-1:0]               ex_memory_addr,
  input  logic                          ex_branch_flag,
  input  logic [PC_W-1:0]               ex_branch_target,
  input  logic [PC_W-1:0]               ex_link_addr,
  input  logic                          ex_is_in_delay,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_PIPES*DATA_W-1:0]   ff_rt,
  output logic [NUM_PIPES*ADDR_W-1:0]   ff_rtaddr,
  output logic [NUM_PIPES-1:0]          ff_wreg,
  output logic [NUM_PIPES*UID_W-1:0]    ff_uid,
  output logic [PC_W-1:0]               ff_memory_addr,
  output logic                          ff_branch_flag,
  output logic [PC_W-1:0]               ff_branch_target,
  output logic [PC_W-1:0]               ff_link_addr,
  output logic                          ff_is_in_delay,
  output logic [15:0]                   stall_cnt
);

  // One bundle as it travels through the handshake. Link address and
  // delay-slot flag are not part of it: they are plain per-cycle registers.
  typedef struct packed {
    logic [NUM_PIPES*DATA_W-1:0] rt;
    logic [NUM_PIPES*ADDR_W-1:0] rtaddr;
    logic [NUM_PIPES-1:0]        wreg;
    logic [NUM_PIPES*UID_W-1:0]  uid;
    logic [PC_W-1:0]             memory_addr;
    logic                        branch_flag;
    logic [PC_W-1:0]             branch_target;
  } bundle_t;

  bundle_t         in_bundle;
  bundle_t         main_q, main_d;
  logic            out_valid_q, out_valid_d;
  logic [PC_W-1:0] link_q;
  logic            delay_q;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic            accept;
  logic            retire;

  // Pack the incoming EX fields into one bundle.
  always_comb begin
    in_bundle.rt            = ex_rt;
    in_bundle.rtaddr        = ex_rtaddr;
    in_bundle.wreg          = ex_wreg;
    in_bundle.uid           = ex_uid;
    in_bundle.memory_addr   = ex_memory_addr;
    in_bundle.branch_flag   = ex_branch_flag;
    in_bundle.branch_target = ex_branch_target;
  end

  assign accept = in_valid & in_ready;
  assign retire = out_valid_q & out_ready;

`ifdef EX_FF_SKID_EN
  bundle_t skid_q, skid_d;
  logic    skid_valid_q, skid_valid_d;

  // Ready depends only on skid occupancy, so it is a register output.
  assign in_ready = !skid_valid_q;

  // Next-state for main and skid entries; order is main first, then skid.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    main_d       = main_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || retire) begin
      // Main is free this edge: refill it from skid first, else from EX.
      if (skid_valid_q) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = in_bundle;
        end
      end else if (accept) begin
        main_d      = in_bundle;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stuck: park the new bundle in skid.
      skid_d       = in_bundle;
      skid_valid_d = 1'b1;
    end
  end

  // Skid occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
    end
  end

  // Skid payload register.
  always_ff @(posedge clk) begin
    // NOTE: payload needs no reset; skid_valid_q alone decides whether it is ever used.
    skid_q <= skid_d;
  end
`else
  // Ready whenever main is empty or being retired this cycle.
  assign in_ready = !out_valid_q | out_ready;

  // Next-state for the single main entry.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    main_d      = main_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      main_d      = in_bundle;
      out_valid_d = 1'b1;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Saturating count of cycles where FF holds a bundle it cannot consume.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Main register, pass-through registers and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      main_q      <= '0;
      out_valid_q <= 1'b0;
      link_q      <= '0;
      delay_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
      link_q      <= ex_link_addr;
      delay_q     <= ex_is_in_delay;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Write enables and branch flag are gated so an empty stage never writes or redirects.
  assign out_valid        = out_valid_q;
  assign ff_rt            = main_q.rt;
  assign ff_rtaddr        = main_q.rtaddr;
  assign ff_wreg          = main_q.wreg & {NUM_PIPES{out_valid_q}};
  assign ff_uid           = main_q.uid;
  assign ff_memory_addr   = main_q.memory_addr;
  assign ff_branch_flag   = main_q.branch_flag & out_valid_q;
  assign ff_branch_target = main_q.branch_target;
  assign ff_link_addr     = link_q;
  assign ff_is_in_delay   = delay_q;
  assign stall_cnt        = stall_cnt_q;

endmodule
